lfsr_gen: RTL and testbench

//  Parametrised Fibonacci LFSR pseudo-random source: generalised width, tap mask, XOR/XNOR feedback, multi-bit advance.

---
 rtl/lfsr_pkg.sv | 45 ++++
 rtl/lfsr_step_comb.sv | 42 ++++
 rtl/lfsr_gen.sv | 124 ++++++++++++
 tb/tb_lfsr_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared helpers for the Fibonacci LFSR generator.
//   lfsr_shift  : one single-bit shift step (LSB-in, shifts toward MSB)
//   lockup_val  : the fixed-point state for a given width / feedback polarity
//   width_mask  : all-ones mask of the low 'width' bits
//   MAXLEN_TAPS : maximal-length tap masks for widths 3..32, bit i = state[i]
// Optional feature macro (used by lfsr_gen): LFSR_LOCKUP_RECOVER_EN
// -----------------------------------------------------------------------------
package lfsr_pkg;

    // Maximal-length tap masks, indexed by width. Bit positions are 0-based.
    localparam logic [31:0] MAXLEN_TAPS [3:32] = '{
        32'h0000_0006, 32'h0000_000C, 32'h0000_0014, 32'h0000_0030,  // 3..6
        32'h0000_0060, 32'h0000_00B8, 32'h0000_0110, 32'h0000_0240,  // 7..10
        32'h0000_0500, 32'h0000_0829, 32'h0000_100D, 32'h0000_2015,  // 11..14
        32'h0000_6000, 32'h0000_D008, 32'h0001_2000, 32'h0002_0400,  // 15..18
        32'h0004_0023, 32'h0009_0000, 32'h0014_0000, 32'h0030_0000,  // 19..22
        32'h0042_0000, 32'h00E1_0000, 32'h0120_0000, 32'h0200_0023,  // 23..26
        32'h0400_0013, 32'h0900_0000, 32'h1400_0000, 32'h2000_0029,  // 27..30
        32'h4800_0000, 32'h8020_0003                                  // 31..32
    };

    // Low 'width' bits set; width=32 wraps 1<<32 to 0, and 0-1 is all-ones.
    function automatic logic [31:0] width_mask(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    // One Fibonacci step. The caller masks the result to its own width,
    // since the shifted-out MSB lands above the active field.
    function automatic logic [31:0] lfsr_shift(input logic [31:0] state,
                                               input logic [31:0] taps,
                                               input logic        xnor_fb);
        logic fb;
        fb = (^(state & taps)) ^ xnor_fb;
        return {state[30:0], fb};
    endfunction

    // XNOR feedback locks at all-ones, XOR feedback locks at all-zeros.
    function automatic logic [31:0] lockup_val(input int unsigned width,
                                               input logic        xnor_fb);
        return xnor_fb ? width_mask(width) : 32'd0;
    endfunction

endpackage

// File: rtl/lfsr_step_comb.sv
// -----------------------------------------------------------------------------
// lfsr_step_comb
// Purely combinational STEP-deep unrolled LFSR shift chain.
// Ports:
//   state_i  in  WIDTH  current state
//   state_o  out WIDTH  state after STEP single-bit shifts
// -----------------------------------------------------------------------------
module lfsr_step_comb
    import lfsr_pkg::*;
#(
    parameter int             WIDTH   = 9,
    parameter logic [WIDTH-1:0] TAPS  = 9'h110,
    parameter bit             XNOR_FB = 1'b1,
    parameter int             STEP    = 1
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] state_o
);

    localparam logic [31:0] MASK   = width_mask(WIDTH);
    localparam logic [31:0] TAPS32 = 32'(TAPS);

    // chain[k] = state after k shifts, carried at 32 bits with the upper
    // bits kept zero by masking each stage.
    logic [31:0] chain [0:STEP];

    assign chain[0] = 32'(state_i);

    generate
        for (genvar gi = 0; gi < STEP; gi++) begin : g_stage
            assign chain[gi+1] = lfsr_shift(chain[gi], TAPS32, XNOR_FB) & MASK;
        end
        if (WIDTH < 32) begin : g_pad
            // Upper bits are always zero; fold them so they are not left dangling.
            logic unused_hi;
            assign unused_hi = ^chain[STEP][31:WIDTH];
        end
    endgenerate

    assign state_o = chain[STEP][WIDTH-1:0];

endmodule

// File: rtl/lfsr_gen.sv
// -----------------------------------------------------------------------------
// lfsr_gen
// Parametrised Fibonacci LFSR pseudo-random source with enable, run-time seed
// load, start-state wrap detection and measured-period reporting.
// Ports:
//   clk      in   1        rising-edge clock
//   reset    in   1        asynchronous, active-high
//   en       in   1        advance STEP shifts this cycle
//   load     in   1        load seed_in (priority over en)
//   seed_in  in   WIDTH    seed captured on load
//   num      out  WIDTH    current state (registered)
//   wrap     out  1        pulse: state just returned to the start state
//   period   out  WIDTH+1  advances between the last two wrap points
//   lockup   out  1        num equals the lockup value (combinational)
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN -- replaces a lockup seed on
// load, and a lockup state seen under en, with SEED.
// -----------------------------------------------------------------------------
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH   = 9,
    parameter logic [WIDTH-1:0] TAPS    = 9'h110,
    parameter bit               XNOR_FB = 1'b1,
    parameter logic [WIDTH-1:0] SEED    = '0,
    parameter int               STEP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] num,
    output logic             wrap,
    output logic [WIDTH:0]   period,
    output logic             lockup
);

    localparam logic [WIDTH-1:0] LOCKUP  = WIDTH'(lockup_val(WIDTH, XNOR_FB));
    localparam logic [WIDTH:0]   CNT_MAX = '1;

    logic [WIDTH-1:0] num_q,    num_d;
    logic [WIDTH-1:0] start_q,  start_d;
    logic [WIDTH:0]   adv_cnt_q, adv_cnt_d;
    logic [WIDTH:0]   period_q, period_d;
    logic             wrap_q,   wrap_d;

    logic [WIDTH-1:0] step_d;
    logic [WIDTH-1:0] seed_sel;
    logic [WIDTH:0]   cnt_inc;

    lfsr_step_comb #(
        .WIDTH   (WIDTH),
        .TAPS    (TAPS),
        .XNOR_FB (XNOR_FB),
        .STEP    (STEP)
    ) u_step (
        .state_i (num_q),
        .state_o (step_d)
    );

    assign lockup = (num_q == LOCKUP);

`ifdef LFSR_LOCKUP_RECOVER_EN
    assign seed_sel = (seed_in == LOCKUP) ? SEED : seed_in;
`else
    assign seed_sel = seed_in;
`endif

    // Saturating increment; also serves as the period value at a wrap.
    assign cnt_inc = (adv_cnt_q == CNT_MAX) ? CNT_MAX : adv_cnt_q + 1'b1;

    always_comb begin
        num_d     = num_q;
        start_d   = start_q;
        adv_cnt_d = adv_cnt_q;
        period_d  = period_q;
        wrap_d    = 1'b0;
        if (load) begin
            num_d     = seed_sel;
            start_d   = seed_sel;
            adv_cnt_d = '0;
        end else if (en) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            if (lockup) begin
                // Escape the fixed point by restarting the sequence from SEED.
                num_d     = SEED;
                start_d   = SEED;
                adv_cnt_d = '0;
            end else
`endif
            begin
                num_d = step_d;
                if (step_d == start_q) begin
                    wrap_d    = 1'b1;
                    period_d  = cnt_inc;
                    adv_cnt_d = '0;
                end else begin
                    adv_cnt_d = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_q     <= SEED;
            start_q   <= SEED;
            adv_cnt_q <= '0;
            period_q  <= '0;
            wrap_q    <= 1'b0;
        end else begin
            num_q     <= num_d;
            start_q   <= start_d;
            adv_cnt_q <= adv_cnt_d;
            period_q  <= period_d;
            wrap_q    <= wrap_d;
        end
    end

    assign num    = num_q;
    assign wrap   = wrap_q;
    assign period = period_q;

endmodule

// File: tb/tb_lfsr_gen.sv
`timescale 1ns/1ps
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       reset, en, load;
    logic [8:0] seed_in;
    logic [8:0] num;
    logic       wrap, lockup;
    logic [9:0] period;

    logic       reset3, en3, load3;
    logic [8:0] seed3;
    logic [8:0] num3;
    logic       wrap3, lockup3;
    logic [9:0] period3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(9), .TAPS(9'h110), .XNOR_FB(1'b1), .SEED(9'h000), .STEP(1)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
        .num(num), .wrap(wrap), .period(period), .lockup(lockup));

    lfsr_gen #(.WIDTH(9), .TAPS(9'h110), .XNOR_FB(1'b1), .SEED(9'h000), .STEP(3)) dut3 (
        .clk(clk), .reset(reset3), .en(en3), .load(load3), .seed_in(seed3),
        .num(num3), .wrap(wrap3), .period(period3), .lockup(lockup3));

    // ---------------- behavioural model (arithmetic view) ----------------
    // Feedback = parity of tapped bits (bits 8 and 4), inverted; new bit enters LSB.
    function automatic int mshift(input int s, input int steps);
        int r;
        r = s;
        for (int k = 0; k < steps; k++)
            r = ((r * 2) + (($countones(r & 'h110) + 1) % 2)) % 512;
        return r;
    endfunction

    function automatic int fix_seed(input int s);
`ifdef LFSR_LOCKUP_RECOVER_EN
        return (s == 511) ? 0 : s;
`else
        return s;
`endif
    endfunction

    function automatic int sat(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    // m_cnt = advances made since the start point
    int m_num, m_start, m_cnt, m_per, m_wrap;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_num <= 0; m_start <= 0; m_cnt <= 0; m_per <= 0; m_wrap <= 0;
        end else if (load) begin
            m_num <= fix_seed(int'(seed_in)); m_start <= fix_seed(int'(seed_in));
            m_cnt <= 0; m_wrap <= 0;
`ifdef LFSR_LOCKUP_RECOVER_EN
        end else if (en && m_num == 511) begin
            m_num <= 0; m_start <= 0; m_cnt <= 0; m_wrap <= 0;
`endif
        end else if (en) begin
            m_num <= mshift(m_num, 1);
            if (mshift(m_num, 1) == m_start) begin
                m_wrap <= 1; m_per <= sat(m_cnt + 1); m_cnt <= 0;
            end else begin
                m_wrap <= 0; m_cnt <= sat(m_cnt + 1);
            end
        end else begin
            m_wrap <= 0;
        end
    end

    int m3_num, m3_start, m3_cnt, m3_per, m3_wrap;
    always @(posedge clk or posedge reset3) begin
        if (reset3) begin
            m3_num <= 0; m3_start <= 0; m3_cnt <= 0; m3_per <= 0; m3_wrap <= 0;
        end else if (en3) begin
            m3_num <= mshift(m3_num, 3);
            if (mshift(m3_num, 3) == m3_start) begin
                m3_wrap <= 1; m3_per <= sat(m3_cnt + 1); m3_cnt <= 0;
            end else begin
                m3_wrap <= 0; m3_cnt <= sat(m3_cnt + 1);
            end
        end else begin
            m3_wrap <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        $display("txn %s: got %0h expected %0h", name, act, exp);
        check(name, act, exp);
    endtask

    // Per-cycle compare against the model, away from the rising edge.
    always @(negedge clk) begin
        check("num",     32'(num),     32'(m_num));
        check("wrap",    32'(wrap),    32'(m_wrap));
        check("period",  32'(period),  32'(m_per));
        check("lockup",  32'(lockup),  32'(m_num == 511));
        check("num3",    32'(num3),    32'(m3_num));
        check("wrap3",   32'(wrap3),   32'(m3_wrap));
        check("period3", 32'(period3), 32'(m3_per));
        check("lockup3", 32'(lockup3), 32'(m3_num == 511));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [8:0] exp6 [6];

    initial begin
        exp6 = '{9'h001, 9'h003, 9'h007, 9'h00F, 9'h01F, 9'h03E};
        reset = 1'b1; en = 1'b0; load = 1'b0; seed_in = '0;
        reset3 = 1'b1; en3 = 1'b0; load3 = 1'b0; seed3 = '0;

        // reset state
        repeat (2) @(negedge clk);
        lit("reset_num",    32'(num),    32'h0);
        lit("reset_wrap",   32'(wrap),   32'h0);
        lit("reset_period", 32'(period), 32'h0);
        lit("reset_lockup", 32'(lockup), 32'h0);
        reset = 1'b0;

        // first six advances
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            lit("seq6_num", 32'(num), 32'(exp6[i]));
            lit("seq6_wrap", 32'(wrap), 32'h0);
        end
        lit("seq6_lockup", 32'(lockup), 32'h0);

        // full period from reset, twice
        en = 1'b0; reset = 1'b1; @(negedge clk); reset = 1'b0;
        en = 1'b1;
        repeat (510) @(negedge clk);
        lit("pre_wrap", 32'(wrap), 32'h0);
        @(negedge clk);
        lit("wrap1_wrap",   32'(wrap),   32'h1);
        lit("wrap1_num",    32'(num),    32'h0);
        lit("wrap1_period", 32'(period), 32'd511);
        repeat (511) @(negedge clk);
        lit("wrap2_wrap",   32'(wrap),   32'h1);
        lit("wrap2_period", 32'(period), 32'd511);

        // alternating enable
        en = 1'b0; reset = 1'b1; @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 1022; i++) begin
            en = (i % 2 == 0);
            @(negedge clk);
        end
        lit("alt_period", 32'(period), 32'd511);
        lit("alt_num",    32'(num),    32'h0);
        lit("alt_wrap",   32'(wrap),   32'h0);

        // load has priority over en
        load = 1'b1; en = 1'b1; seed_in = 9'h0A5;
        @(negedge clk);
        lit("load_num",  32'(num),  32'h0A5);
        lit("load_wrap", 32'(wrap), 32'h0);
        load = 1'b0;
        repeat (510) @(negedge clk);
        lit("load_prewrap", 32'(wrap), 32'h0);
        @(negedge clk);
        lit("load_wrap_pulse", 32'(wrap),   32'h1);
        lit("load_wrap_num",   32'(num),    32'h0A5);
        lit("load_wrap_per",   32'(period), 32'd511);

        // lockup seed
        en = 1'b0; load = 1'b1; seed_in = 9'h1FF;
        @(negedge clk);
        load = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
        lit("lock_load_num",    32'(num),    32'h000);
        lit("lock_load_lockup", 32'(lockup), 32'h0);
`else
        lit("lock_load_num",    32'(num),    32'h1FF);
        lit("lock_load_lockup", 32'(lockup), 32'h1);
`endif
        en = 1'b1;
        repeat (3) @(negedge clk);
`ifdef LFSR_LOCKUP_RECOVER_EN
        lit("lock_en_num",    32'(num),    32'h007);
        lit("lock_en_lockup", 32'(lockup), 32'h0);
`else
        lit("lock_en_num",    32'(num),    32'h1FF);
        lit("lock_en_lockup", 32'(lockup), 32'h1);
`endif
        en = 1'b0;

        // STEP=3 instance
        reset3 = 1'b0; en3 = 1'b1;
        @(negedge clk);
        lit("step3_num_a", 32'(num3), 32'h007);
        @(negedge clk);
        lit("step3_num_b", 32'(num3), 32'h03E);
        @(posedge clk);
        #2 reset3 = 1'b1;
        #1 lit("step3_async_reset", 32'(num3), 32'h000);
        @(negedge clk);
        reset3 = 1'b0; en3 = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
